mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the multi-cycle core. Sits between the execute stage and wb_stage.
- Takes one instruction at a time from execute. Issues at most one data-memory request per instruction and waits a variable number of cycles for the memory response.
- Hands wb_stage a one-cycle valid pulse with the ALU result, loaded data, destination register and load flag.
- Checks alignment and performs byte-lane selection and merging.

Parameters:
- REGISTER_WIDTH, 5, width of the destination register index.
- DATA_WIDTH, 32, data word width. Fixed at 32 for byte-lane logic.
- ADDR_WIDTH, 32, byte address width. Must be <= DATA_WIDTH; the address is alu_result_i[ADDR_WIDTH-1:0].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  instruction from execute is present.
- is_load_i  in  1  instruction is a load.
- is_store_i  in  1  instruction is a store. is_load_i and is_store_i are never both 1.
- is_byte_i  in  1  access size is byte; 0 means word.
- reg_wr_en_i  in  1  instruction writes a register.
- wr_reg_i  in  REGISTER_WIDTH  destination register.
- alu_result_i  in  DATA_WIDTH  ALU result; also the effective byte address.
- store_data_i  in  DATA_WIDTH  store source operand.
- stall_o  out  1  stage busy; execute must hold and not present new work.
- mem_req_o  out  1  data-memory request.
- mem_we_o  out  1  request is a write.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_ready_i  in  1  memory completes the current request; rdata valid this cycle for reads.
- mem_rdata_i  in  DATA_WIDTH  read data.
- valid_o  out  1  one-cycle pulse to wb_stage.
- reg_wr_en_o  out  1  to wb_stage.
- wr_reg_o  out  REGISTER_WIDTH  to wb_stage.
- alu_result_o  out  DATA_WIDTH  to wb_stage.
- data_from_mem_o  out  DATA_WIDTH  to wb_stage.
- is_load_o  out  1  to wb_stage.
- misalign_o  out  1  pulses with valid_o when the access was a misaligned word access.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including stall_o, mem_req_o, valid_o and misalign_o.
  - A reset while in WAIT abandons the request; a late mem_ready_i after reset is ignored.
- Outputs are registered except stall_o. stall_o = (state != IDLE).
- States: IDLE, WAIT, RESP.
- IDLE:
  - A transaction is accepted when valid_i=1.
  - All inputs are latched on acceptance.
  - Memory op (is_load_i|is_store_i) that is aligned, or any byte access:
    - Next cycle: mem_req_o=1 and mem_we_o=is_store_i.
    - mem_addr_o = addr with bits [1:0] cleared.
    - Byte access: mem_be_o = 1<<addr[1:0] and mem_wdata_o = store byte replicated into all 4 lanes.
    - Word access: mem_be_o = 4'hF and mem_wdata_o = store_data_i.
    - Go to WAIT.
  - Word memory op with addr[1:0] != 0:
    - No request is issued; go to RESP with misalign_o=1 and reg_wr_en_o=0.
  - Non-memory op:
    - Go to RESP; data_from_mem_o=0.
- WAIT:
  - mem_req_o and all mem_* outputs are held stable until the cycle mem_ready_i=1. Zero-wait memory is legal: mem_ready_i may be 1 in the first WAIT cycle.
  - On mem_ready_i=1, data_from_mem_o is registered:
    - Word load: data_from_mem_o = mem_rdata_i.
    - Byte load: data_from_mem_o = zero-extended mem_rdata_i[8*addr[1:0] +: 8].
    - Store: data_from_mem_o = 0.
  - mem_req_o drops to 0 the following cycle; go to RESP.
  - mem_ready_i outside WAIT is ignored.
- RESP:
  - valid_o=1 for exactly one cycle, with the latched reg_wr_en, wr_reg, alu_result and is_load. reg_wr_en_o is forced to 0 on misalign.
  - Go to IDLE. valid_o and misalign_o return to 0.
- Latency from acceptance to valid_o:
  - Non-memory or misaligned: 2 cycles.
  - Memory: 3 + N cycles, where N = WAIT cycles before mem_ready_i.
- valid_i while stall_o=1 is not sampled. Upstream holds its data.
- Back-to-back: a new valid_i can be accepted the cycle after RESP (IDLE).
- Outputs other than valid_o/misalign_o/mem_req_o hold their last values between transactions.

Test Plan:
- Reset mid-WAIT: load issued, mem_ready_i held 0, rst_i=0 for 1 cycle, then mem_ready_i=1 -> all outputs 0, no valid_o, stall_o=0, state IDLE.
- Non-memory op: valid_i=1, alu_result_i=0x1234, wr_reg_i=7, reg_wr_en_i=1 -> valid_o pulse 2 cycles later with alu_result_o=0x1234, wr_reg_o=7, reg_wr_en_o=1, is_load_o=0, mem_req_o never asserted.
- Word load with 3-cycle wait: addr 0x100, mem_rdata_i=0xDEADBEEF on ready -> mem_req_o held with mem_addr_o=0x100, mem_be_o=F, we=0. Then data_from_mem_o=0xDEADBEEF, is_load_o=1, single valid_o pulse.
- Byte load at 0x103, rdata=0xA1B2C3D4, zero-wait memory -> mem_addr_o=0x100, mem_be_o=4'b1000, data_from_mem_o=0x000000A1.
- Byte store at 0x101, store_data_i=0x55 -> mem_we_o=1, mem_be_o=4'b0010, mem_wdata_o=0x55555555, valid_o after ready with data_from_mem_o=0.
- Misaligned word store at 0x102 -> no mem_req_o, valid_o and misalign_o pulse together with reg_wr_en_o=0. A new op is accepted the next IDLE cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory request per instruction, waits for
// the response, aligns/merges byte lanes and hands a one-cycle result to writeback.
module mem_stage #(
    parameter int unsigned REGISTER_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic                      is_byte_i,
    input  logic                      reg_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     store_data_i,
    output logic                      stall_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      valid_o,
    output logic                      reg_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] wr_reg_o,
    output logic [DATA_WIDTH-1:0]     alu_result_o,
    output logic [DATA_WIDTH-1:0]     data_from_mem_o,
    output logic                      is_load_o,
    output logic                      misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                    state_q, state_d;
    logic                      req_q, req_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic                      valid_q, valid_d, mis_q, mis_d;
    logic                      out_rwe_q, out_rwe_d, out_ld_q, out_ld_d;
    logic [REGISTER_WIDTH-1:0] out_reg_q, out_reg_d;
    logic [DATA_WIDTH-1:0]     out_alu_q, out_alu_d;

    // Transaction fields captured at acceptance
    logic                      lat_ld_q, lat_ld_d, lat_st_q, lat_st_d, lat_byte_q, lat_byte_d;
    logic                      lat_rwe_q, lat_rwe_d, lat_mis_q, lat_mis_d;
    logic [REGISTER_WIDTH-1:0] lat_reg_q, lat_reg_d;
    logic [DATA_WIDTH-1:0]     lat_alu_q, lat_alu_d;

    logic [1:0] in_off;
    logic       in_mem_op, in_mis;

    assign in_off    = alu_result_i[1:0];
    assign in_mem_op = is_load_i | is_store_i;
    assign in_mis    = in_mem_op & ~is_byte_i & (in_off != 2'b00);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        mis_d      = 1'b0;
        out_rwe_d  = out_rwe_q;
        out_ld_d   = out_ld_q;
        out_reg_d  = out_reg_q;
        out_alu_d  = out_alu_q;
        lat_ld_d   = lat_ld_q;
        lat_st_d   = lat_st_q;
        lat_byte_d = lat_byte_q;
        lat_rwe_d  = lat_rwe_q;
        lat_mis_d  = lat_mis_q;
        lat_reg_d  = lat_reg_q;
        lat_alu_d  = lat_alu_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    lat_ld_d   = is_load_i;
                    lat_st_d   = is_store_i;
                    lat_byte_d = is_byte_i;
                    lat_rwe_d  = reg_wr_en_i;
                    lat_mis_d  = in_mis;
                    lat_reg_d  = wr_reg_i;
                    lat_alu_d  = alu_result_i;
                    if (in_mem_op && !in_mis) begin
                        req_d   = 1'b1;
                        we_d    = is_store_i;
                        addr_d  = {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
                        be_d    = is_byte_i ? (4'b0001 << in_off) : 4'hF;
                        wdata_d = is_byte_i ? {4{store_data_i[7:0]}} : store_data_i;
                        state_d = S_WAIT;
                    end else begin
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    req_d = 1'b0;
                    if (lat_st_q) begin
                        rdata_d = '0;
                    end else if (lat_byte_q) begin
                        rdata_d = DATA_WIDTH'(mem_rdata_i[{lat_alu_q[1:0], 3'b000} +: 8]);
                    end else begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                valid_d   = 1'b1;
                mis_d     = lat_mis_q;
                out_rwe_d = lat_rwe_q & ~lat_mis_q;
                out_ld_d  = lat_ld_q;
                out_reg_d = lat_reg_q;
                out_alu_d = lat_alu_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            out_rwe_q  <= 1'b0;
            out_ld_q   <= 1'b0;
            out_reg_q  <= '0;
            out_alu_q  <= '0;
            lat_ld_q   <= 1'b0;
            lat_st_q   <= 1'b0;
            lat_byte_q <= 1'b0;
            lat_rwe_q  <= 1'b0;
            lat_mis_q  <= 1'b0;
            lat_reg_q  <= '0;
            lat_alu_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
            out_rwe_q  <= out_rwe_d;
            out_ld_q   <= out_ld_d;
            out_reg_q  <= out_reg_d;
            out_alu_q  <= out_alu_d;
            lat_ld_q   <= lat_ld_d;
            lat_st_q   <= lat_st_d;
            lat_byte_q <= lat_byte_d;
            lat_rwe_q  <= lat_rwe_d;
            lat_mis_q  <= lat_mis_d;
            lat_reg_q  <= lat_reg_d;
            lat_alu_q  <= lat_alu_d;
        end
    end

    assign stall_o         = (state_q != S_IDLE);
    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_be_o        = be_q;
    assign mem_wdata_o     = wdata_q;
    assign valid_o         = valid_q;
    assign misalign_o      = mis_q;
    assign reg_wr_en_o     = out_rwe_q;
    assign wr_reg_o        = out_reg_q;
    assign alu_result_o    = out_alu_q;
    assign data_from_mem_o = rdata_q;
    assign is_load_o       = out_ld_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single transactions plus hand-written
// reset-mid-WAIT and back-to-back sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i, is_load_i, is_store_i, is_byte_i, reg_wr_en_i;
    logic [4:0]  wr_reg_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        valid_o, reg_wr_en_o;
    logic [4:0]  wr_reg_o;
    logic [31:0] alu_result_o, data_from_mem_o;
    logic        is_load_o, misalign_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .is_byte_i(is_byte_i), .reg_wr_en_i(reg_wr_en_i),
        .wr_reg_i(wr_reg_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
        .reg_wr_en_o(reg_wr_en_o), .wr_reg_o(wr_reg_o), .alu_result_o(alu_result_o),
        .data_from_mem_o(data_from_mem_o), .is_load_o(is_load_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic        ld, st, byt, rwe;
        logic [4:0]  wr_reg;
        logic [31:0] alu, sdata, rdata;
        int          wait_n;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_data;
        logic        exp_mis, exp_rwe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, st, byt, rwe, input logic [4:0] wr_reg,
                                input logic [31:0] alu, sdata, rdata, input int wait_n,
                                input logic exp_req, exp_we, input logic [31:0] exp_addr,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata, exp_data,
                                input logic exp_mis, exp_rwe);
        vec_t v;
        v.ld = ld; v.st = st; v.byt = byt; v.rwe = rwe; v.wr_reg = wr_reg;
        v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.wait_n = wait_n;
        v.exp_req = exp_req; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_data = exp_data; v.exp_mis = exp_mis; v.exp_rwe = exp_rwe;
        return v;
    endfunction

    task automatic drive_op(input logic ld, st, byt, rwe, input logic [4:0] wr_reg,
                            input logic [31:0] alu, sdata);
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; is_byte_i = byt;
        reg_wr_en_i = rwe; wr_reg_i = wr_reg; alu_result_i = alu; store_data_i = sdata;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after valid_o.
    task automatic run_txn(input vec_t v, input int idx);
        int  reqs;
        bit  done;
        int  exp_lat;
        reqs = 0;
        done = 1'b0;
        exp_lat = v.exp_req ? 3 + v.wait_n : 2;
        drive_op(v.ld, v.st, v.byt, v.rwe, v.wr_reg, v.alu, v.sdata);
        mem_rdata_i = v.rdata;
        mem_ready_i = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c == 1) check($sformatf("v%0d stall", idx), 32'(stall_o), 32'd1);
            if (mem_req_o) begin
                check($sformatf("v%0d addr", idx), mem_addr_o, v.exp_addr);
                check($sformatf("v%0d be", idx), 32'(mem_be_o), 32'(v.exp_be));
                check($sformatf("v%0d we", idx), 32'(mem_we_o), 32'(v.exp_we));
                check($sformatf("v%0d wdata", idx), mem_wdata_o, v.exp_wdata);
                mem_ready_i = (reqs == v.wait_n);
                reqs++;
            end else begin
                mem_ready_i = 1'b0;
            end
            if (valid_o) begin
                done = 1'b1;
                check($sformatf("v%0d latency", idx), 32'(c), 32'(exp_lat));
                check($sformatf("v%0d misalign", idx), 32'(misalign_o), 32'(v.exp_mis));
                check($sformatf("v%0d reg_wr_en", idx), 32'(reg_wr_en_o), 32'(v.exp_rwe));
                check($sformatf("v%0d wr_reg", idx), 32'(wr_reg_o), 32'(v.wr_reg));
                check($sformatf("v%0d alu", idx), alu_result_o, v.alu);
                check($sformatf("v%0d data", idx), data_from_mem_o, v.exp_data);
                check($sformatf("v%0d is_load", idx), 32'(is_load_o), 32'(v.ld));
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL v%0d timeout: got no valid_o, expected valid_o within 40 cycles", idx);
        end
        check($sformatf("v%0d req_cycles", idx), 32'(reqs), v.exp_req ? 32'(v.wait_n + 1) : 32'd0);
        mem_ready_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d valid_drop", idx), 32'(valid_o), 32'd0);
        check($sformatf("v%0d mis_drop", idx), 32'(misalign_o), 32'd0);
        check($sformatf("v%0d idle", idx), 32'(stall_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        check({tag, " req"}, 32'(mem_req_o), 32'd0);
        check({tag, " we"}, 32'(mem_we_o), 32'd0);
        check({tag, " addr"}, mem_addr_o, 32'd0);
        check({tag, " be"}, 32'(mem_be_o), 32'd0);
        check({tag, " wdata"}, mem_wdata_o, 32'd0);
        check({tag, " valid"}, 32'(valid_o), 32'd0);
        check({tag, " mis"}, 32'(misalign_o), 32'd0);
        check({tag, " rwe"}, 32'(reg_wr_en_o), 32'd0);
        check({tag, " wr_reg"}, 32'(wr_reg_o), 32'd0);
        check({tag, " alu"}, alu_result_o, 32'd0);
        check({tag, " data"}, data_from_mem_o, 32'd0);
        check({tag, " is_load"}, 32'(is_load_o), 32'd0);
    endtask

    vec_t vecs[9];
    bit   saw_valid;

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
        reg_wr_en_i = 1'b0; wr_reg_i = '0; alu_result_i = '0; store_data_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;

        //            ld st by rwe reg  alu        sdata         rdata        N  req we addr       be    wdata         data          mis rwe
        vecs[0] = mk(0, 0, 0, 1, 5'd7,  32'h1234, 32'h0,        32'h0,        0, 0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        0, 1);
        vecs[1] = mk(1, 0, 0, 1, 5'd3,  32'h100,  32'h0,        32'hDEADBEEF, 3, 1, 0, 32'h100,  4'hF, 32'h0,        32'hDEADBEEF, 0, 1);
        vecs[2] = mk(1, 0, 1, 1, 5'd4,  32'h103,  32'h77,       32'hA1B2C3D4, 0, 1, 0, 32'h100,  4'h8, 32'h77777777, 32'hA1,       0, 1);
        vecs[3] = mk(0, 1, 1, 0, 5'd0,  32'h101,  32'h55,       32'h12345678, 1, 1, 1, 32'h100,  4'h2, 32'h55555555, 32'h0,        0, 0);
        vecs[4] = mk(0, 1, 0, 1, 5'd5,  32'h102,  32'h99,       32'h0,        0, 0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        1, 0);
        vecs[5] = mk(0, 1, 0, 0, 5'd0,  32'h204,  32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 1, 32'h204,  4'hF, 32'hCAFEF00D, 32'h0,        0, 0);
        vecs[6] = mk(1, 0, 1, 1, 5'd12, 32'h202,  32'h0,        32'h11223344, 2, 1, 0, 32'h200,  4'h4, 32'h0,        32'h22,       0, 1);
        vecs[7] = mk(1, 0, 0, 1, 5'd9,  32'h301,  32'h0,        32'h0,        0, 0, 0, 32'h0,    4'h0, 32'h0,        32'h0,        1, 0);
        vecs[8] = mk(1, 0, 1, 1, 5'd31, 32'h100,  32'hAB,       32'h123456FF, 0, 1, 0, 32'h100,  4'h1, 32'hABABABAB, 32'hFF,       0, 1);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Hold between transactions: mem_* keep the last request's values
        check("hold addr", mem_addr_o, 32'h100);
        check("hold wdata", mem_wdata_o, 32'hABABABAB);

        // Back-to-back: misaligned store, then a new op accepted in the valid_o cycle
        drive_op(0, 1, 0, 1, 5'd5, 32'h102, 32'h99);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("b2b stall1", 32'(stall_o), 32'd1);
        check("b2b req1", 32'(mem_req_o), 32'd0);
        @(posedge clk); #1;
        check("b2b valid1", 32'(valid_o), 32'd1);
        check("b2b mis1", 32'(misalign_o), 32'd1);
        check("b2b rwe1", 32'(reg_wr_en_o), 32'd0);
        check("b2b idle", 32'(stall_o), 32'd0);
        drive_op(0, 0, 0, 1, 5'd9, 32'hABC, 32'h0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("b2b valid_gap", 32'(valid_o), 32'd0);
        check("b2b stall2", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        check("b2b valid2", 32'(valid_o), 32'd1);
        check("b2b mis2", 32'(misalign_o), 32'd0);
        check("b2b alu2", alu_result_o, 32'hABC);
        check("b2b reg2", 32'(wr_reg_o), 32'd9);
        check("b2b rwe2", 32'(reg_wr_en_o), 32'd1);
        @(posedge clk); #1;

        // Reset while a load is waiting; a late ready must be ignored
        drive_op(1, 0, 0, 1, 5'd3, 32'h400, 32'h0);
        mem_rdata_i = 32'h87654321;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("rstw req_before", 32'(mem_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check_all_zero("rstw");
        @(negedge clk);
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (valid_o || mem_req_o || stall_o) saw_valid = 1'b1;
        end
        mem_ready_i = 1'b0;
        check("rstw late_ready_ignored", 32'(saw_valid), 32'd0);
        check("rstw data", data_from_mem_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
